// File: rtl/fifo_rd_streamer.sv
// ---------------------------------------------------------------------------
// fifo_rd_streamer
//   Read-side master for a FIFO with a 1-cycle read latency. Issues rd_en
//   whenever the FIFO is non-empty and the local skid buffer has room for
//   every word already buffered or in flight. Returned words land in a
//   circular skid buffer that is presented downstream as a valid/ready
//   stream. Also counts stream handshakes and holds a sticky underflow flag.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   en              allow new FIFO reads (an in-flight word still lands)
//   fifo_data_out   FIFO read data, valid the cycle after an accepted read
//   fifo_empty      FIFO empty flag
//   fifo_underflow  FIFO underflow flag
//   fifo_rd_en      FIFO read request
//   m_data/m_valid  downstream stream data / valid
//   m_ready         downstream ready
//   rd_count        number of stream handshakes, wraps modulo 2^CNT_W
//   underflow_err   sticky underflow indication
//   clr_err         synchronous clear of underflow_err (set has priority)
// ---------------------------------------------------------------------------
module fifo_rd_streamer #(
    parameter int FIFO_WIDTH = 16,
    parameter int SKID_DEPTH = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_W-1:0]      rd_count,
    output logic                  underflow_err,
    input  logic                  clr_err
);

    localparam int PTR_W = $clog2(SKID_DEPTH);
    // Occupancy plus the in-flight word can reach SKID_DEPTH, so size for +1 headroom.
    localparam int OCC_W = $clog2(SKID_DEPTH + 2);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(SKID_DEPTH - 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(SKID_DEPTH);

    logic [FIFO_WIDTH-1:0] skid_q [SKID_DEPTH];
    logic [FIFO_WIDTH-1:0] skid_d [SKID_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      buf_cnt_q, buf_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_W-1:0]      rd_count_q, rd_count_d;
    logic                  underflow_err_q, underflow_err_d;

    logic [OCC_W-1:0]      occ;
    logic                  push;
    logic                  pop;

    // Pointers wrap explicitly so SKID_DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        skid_d          = skid_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        buf_cnt_d       = buf_cnt_q;
        rd_count_d      = rd_count_q;
        underflow_err_d = underflow_err_q;

        // Credit check uses registered state only, so m_ready never reaches rd_en.
        occ        = buf_cnt_q + OCC_W'(inflight_q);
        fifo_rd_en = en && !fifo_empty && (occ < DEPTH_OCC);
        inflight_d = fifo_rd_en;

        push = inflight_q;
        pop  = (buf_cnt_q != '0) && m_ready;

        if (push) begin
            skid_d[wr_ptr_q] = fifo_data_out;
            wr_ptr_d         = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d   = next_ptr(rd_ptr_q);
            rd_count_d = rd_count_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   buf_cnt_d = buf_cnt_q + 1'b1;
            2'b01:   buf_cnt_d = buf_cnt_q - 1'b1;
            default: buf_cnt_d = buf_cnt_q;
        endcase

        if (fifo_underflow) begin
            underflow_err_d = 1'b1;
        end else if (clr_err) begin
            underflow_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q          <= '{default: '0};
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            buf_cnt_q       <= '0;
            inflight_q      <= 1'b0;
            rd_count_q      <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            skid_q          <= skid_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            buf_cnt_q       <= buf_cnt_d;
            inflight_q      <= inflight_d;
            rd_count_q      <= rd_count_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign m_data        = skid_q[rd_ptr_q];
    assign m_valid       = (buf_cnt_q != '0);
    assign rd_count      = rd_count_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_streamer
//   Directed bench for fifo_rd_streamer. A small FIFO model with a 1-cycle
//   read latency feeds the DUT; a monitor records every stream handshake and
//   every rd_en cycle. Expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_fifo_rd_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] fifo_data_out;
    logic        fifo_empty;
    logic        fifo_underflow;
    logic        fifo_rd_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] rd_count;
    logic        underflow_err;
    logic        clr_err;

    fifo_rd_streamer #(.FIFO_WIDTH(16), .SKID_DEPTH(3), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .fifo_data_out  (fifo_data_out),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .rd_count       (rd_count),
        .underflow_err  (underflow_err),
        .clr_err        (clr_err)
    );

    always #5 clk = ~clk;

    // FIFO model: head advances in the clocked process, tail only from stimulus.
    logic [15:0] fifo_mem [64];
    int          head = 0;
    int          tail = 0;
    logic        force_empty = 1'b0;

    assign fifo_empty = force_empty || (head == tail);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data_out <= fifo_mem[head];
            head          <= head + 1;
        end
    end

    // Monitor, sampled on the falling edge.
    logic [15:0] got_data [128];
    int          got_cyc  [128];
    int          got_n   = 0;
    int          rden_n  = 0;
    int          run     = 0;
    int          max_run = 0;
    int          cyc     = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && m_valid && m_ready) begin
            got_data[got_n] <= m_data;
            got_cyc[got_n]  <= cyc;
            got_n           <= got_n + 1;
        end
        if (fifo_rd_en) begin
            rden_n <= rden_n + 1;
            run    <= run + 1;
            if (run + 1 > max_run) max_run <= run + 1;
        end else begin
            run <= 0;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input logic [15:0] first);
        for (int i = 0; i < n; i++) begin
            fifo_mem[tail] = first + 16'(i);
            tail++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rb;

        rst_n          = 1'b0;
        en             = 1'b0;
        m_ready        = 1'b1;
        fifo_underflow = 1'b0;
        clr_err        = 1'b0;
        tick(3);
        chk("rst_m_valid",    32'(m_valid),       0);
        chk("rst_rd_en",      32'(fifo_rd_en),    0);
        chk("rst_rd_count",   32'(rd_count),      0);
        chk("rst_m_data",     32'(m_data),        0);
        chk("rst_underflow",  32'(underflow_err), 0);
        rst_n = 1'b1;
        tick(2);

        // Streaming: 8 words, always ready.
        load(8, 16'h0001);
        base = got_n;
        rb   = rden_n;
        en   = 1'b1;
        tick(1);
        chk("t2_rd_en_first", 32'(fifo_rd_en), 1);
        chk("t2_valid_lat1",  32'(m_valid),    0);
        tick(1);
        chk("t2_valid_lat2",  32'(m_valid),    1);
        chk("t2_data_lat2",   32'(m_data),     32'h0001);
        tick(12);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_word%0d", i), 32'(got_data[base + i]), 32'(i + 1));
        chk("t2_count_words", 32'(got_n - base), 8);
        chk("t2_back_to_back", 32'(got_cyc[base + 7] - got_cyc[base]), 7);
        chk("t2_rd_en_cycles", 32'(rden_n - rb), 8);
        chk("t2_rd_en_run",    32'(max_run), 8);
        chk("t2_rd_count",     32'(rd_count), 8);
        chk("t2_no_underflow", 32'(underflow_err), 0);

        // Backpressure: only three reads until the stream drains.
        m_ready = 1'b0;
        load(8, 16'h0101);
        base = got_n;
        rb   = rden_n;
        tick(10);
        chk("t3_reads",      32'(rden_n - rb),    3);
        chk("t3_buf_cnt",    32'(dut.buf_cnt_q),  3);
        chk("t3_valid",      32'(m_valid),        1);
        chk("t3_data_hold0", 32'(m_data),         32'h0101);
        tick(4);
        chk("t3_data_hold1", 32'(m_data),         32'h0101);
        chk("t3_reads_hold", 32'(rden_n - rb),    3);
        m_ready = 1'b1;
        tick(14);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t3_word%0d", i), 32'(got_data[base + i]), 32'h0101 + 32'(i));
        chk("t3_count_words", 32'(got_n - base), 8);
        chk("t3_rd_count",    32'(rd_count), 16);

        // Reset mid-stream with two words buffered.
        m_ready = 1'b0;
        load(2, 16'h0201);
        tick(6);
        chk("t1_pre_buf_cnt", 32'(dut.buf_cnt_q), 2);
        chk("t1_pre_valid",   32'(m_valid),       1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_valid",    32'(m_valid),    0);
        chk("t1_rd_count", 32'(rd_count),   0);
        chk("t1_rd_en",    32'(fifo_rd_en), 0);
        chk("t1_m_data",   32'(m_data),     0);
        tick(2);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        tick(3);
        chk("t1_post_valid", 32'(m_valid), 0);

        // Empty flag blocks reads; dropping en keeps the in-flight word.
        en          = 1'b0;
        force_empty = 1'b1;
        load(3, 16'h0301);
        en = 1'b1;
        rb = rden_n;
        tick(5);
        chk("t4_empty_no_rd", 32'(rden_n - rb), 0);
        base        = got_n;
        en          = 1'b0;
        force_empty = 1'b0;
        tick(1);
        en = 1'b1;
        tick(1);
        en = 1'b0;
        tick(6);
        chk("t4_single_read", 32'(rden_n - rb),  1);
        chk("t4_delivered",   32'(got_n - base), 1);
        chk("t4_word",        32'(got_data[base]), 32'h0301);
        chk("t4_rd_count",    32'(rd_count), 1);
        en = 1'b1;
        tick(8);
        chk("t4_drain_word1", 32'(got_data[base + 1]), 32'h0302);
        chk("t4_drain_word2", 32'(got_data[base + 2]), 32'h0303);

        // Sticky underflow error, set beats clear.
        chk("t5_err_idle", 32'(underflow_err), 0);
        fifo_underflow = 1'b1;
        tick(1);
        fifo_underflow = 1'b0;
        chk("t5_err_set", 32'(underflow_err), 1);
        tick(3);
        chk("t5_err_sticky", 32'(underflow_err), 1);
        fifo_underflow = 1'b1;
        clr_err        = 1'b1;
        tick(1);
        fifo_underflow = 1'b0;
        chk("t5_set_wins", 32'(underflow_err), 1);
        tick(1);
        clr_err = 1'b0;
        chk("t5_cleared", 32'(underflow_err), 0);

        // Wrap: 10 words with ready toggling.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        en    = 1'b0;
        load(10, 16'h0001);
        base = got_n;
        en   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            m_ready = (i % 2 == 0);
            tick(1);
        end
        m_ready = 1'b1;
        tick(4);
        for (int i = 0; i < 10; i++)
            chk($sformatf("t6_word%0d", i), 32'(got_data[base + i]), 32'(i + 1));
        chk("t6_count_words", 32'(got_n - base),  10);
        chk("t6_rd_count",    32'(rd_count),      10);
        chk("t6_wr_ptr",      32'(dut.wr_ptr_q),  1);
        chk("t6_rd_ptr",      32'(dut.rd_ptr_q),  1);
        chk("t6_empty_out",   32'(m_valid),       0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
